// File: rtl/lfsr_arb_pkg.sv
// Shared types and helpers for the LFSR word arbiter: FSM state, tap mask,
// width helpers and the round-robin pick.
package lfsr_arb_pkg;

    // Largest supported requester count; the pick function works on this width.
    localparam int unsigned MAX_REQ = 8;

    // x^8 + x^4 + x^3 + x^2 + 1, left-shifting Galois form.
    localparam logic [7:0] LFSR8_TAPS = 8'h1D;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Width of a counter that must hold 0..chunks inclusive.
    function automatic int unsigned cnt_width(input int unsigned chunks);
        return $clog2(chunks + 1);
    endfunction

    // Width of a requester index.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // First set request at or after ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int unsigned        num_req);
        rr_pick_t    r;
        int unsigned k;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < num_req && !r.found) begin
                k = (32'(ptr) + i) % num_req;
                if (req[k[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_word_arbiter_lfsr.sv
// Galois LFSR random-bit generator. Advances BITS_PER_CLOCK steps per
// enabled cycle; the chunk appears one cycle later with lfsr_valid_o.
// The first bit shifted out of the register lands in the chunk MSB.
module galois_lfsr #(
    parameter int unsigned            LFSR_WIDTH     = 8,
    parameter int unsigned            BITS_PER_CLOCK = 1,
    parameter int unsigned            LFSR_SEED      = 1,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_TAPS      = LFSR_WIDTH'(8'h1D)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable_i,
    output logic [BITS_PER_CLOCK-1:0] lfsr_out_o,
    output logic                      lfsr_valid_o
);

    if (LFSR_WIDTH'(LFSR_SEED) == '0) begin : g_bad_seed
        $error("galois_lfsr: an all-zero seed locks the register");
    end

    logic [LFSR_WIDTH-1:0]     state_q, state_d;
    logic [BITS_PER_CLOCK-1:0] chunk_d, out_q;
    logic                      valid_q;
    logic [LFSR_WIDTH-1:0]     walk;

    // Step the register BITS_PER_CLOCK times, collecting the shifted-out bits.
    always_comb begin
        walk    = state_q;
        chunk_d = '0;
        for (int unsigned i = 0; i < BITS_PER_CLOCK; i++) begin
            chunk_d[BITS_PER_CLOCK-1-i] = walk[LFSR_WIDTH-1];
            walk = {walk[LFSR_WIDTH-2:0], 1'b0} ^ (walk[LFSR_WIDTH-1] ? LFSR_TAPS : '0);
        end
        state_d = walk;
    end

    // Register state and the output chunk only on enabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LFSR_WIDTH'(LFSR_SEED);
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= enable_i;
            if (enable_i) begin
                state_q <= state_d;
                out_q   <= chunk_d;
            end
        end
    end

    assign lfsr_out_o   = out_q;
    assign lfsr_valid_o = valid_q;

endmodule

// File: rtl/lfsr_word_arbiter.sv
// Round-robin arbiter sharing one Galois LFSR among NUM_REQ requesters.
// Each grant collects WORD_WIDTH/BITS_PER_CLOCK chunks into one word and
// presents it with a valid/ready handshake.
module lfsr_word_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned WORD_WIDTH     = 8,
    parameter int unsigned BITS_PER_CLOCK = 1,
    parameter int unsigned LFSR_SEED      = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [id_width(NUM_REQ)-1:0] rsp_id,
    output logic [WORD_WIDTH-1:0]        rsp_data,
    input  logic                         rsp_ready,
    output logic                         busy
);

    localparam int unsigned C     = WORD_WIDTH / BITS_PER_CLOCK;
    localparam int unsigned CNT_W = cnt_width(C);
    localparam int unsigned ID_W  = id_width(NUM_REQ);

    if (WORD_WIDTH % BITS_PER_CLOCK != 0) begin : g_bad_word
        $error("lfsr_word_arbiter: WORD_WIDTH must be a multiple of BITS_PER_CLOCK");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_req
        $error("lfsr_word_arbiter: NUM_REQ must be in 2..8");
    end
    if (BITS_PER_CLOCK < 1 || BITS_PER_CLOCK > 8) begin : g_bad_bpc
        $error("lfsr_word_arbiter: BITS_PER_CLOCK must be in 1..8");
    end

    arb_state_t                state_q, state_d;
    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          issued_q, issued_d;
    logic [CNT_W-1:0]          collected_q, collected_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
    logic [WORD_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                      busy_q;

    logic                      lfsr_en;
    logic [BITS_PER_CLOCK-1:0] lfsr_out;
    logic                      lfsr_valid;
    logic [MAX_REQ-1:0]        req_pad;
    rr_pick_t                  pick;

    galois_lfsr #(
        .LFSR_WIDTH     (8),
        .BITS_PER_CLOCK (BITS_PER_CLOCK),
        .LFSR_SEED      (LFSR_SEED),
        .LFSR_TAPS      (LFSR8_TAPS)
    ) u_lfsr (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_i     (lfsr_en),
        .lfsr_out_o   (lfsr_out),
        .lfsr_valid_o (lfsr_valid)
    );

    // Next-state, acceptance, generator enable and word assembly.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        issued_d    = issued_q;
        collected_d = collected_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        lfsr_en     = 1'b0;

        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = req_valid;
        pick                   = rr_pick(req_pad, 3'(rr_ptr_q), NUM_REQ);

        case (state_q)
            IDLE: begin
                // Gated by reset_n so req_ready is quiet while reset is held.
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = reset_n && pick.found && (pick.idx == 3'(i));
                end
                if (pick.found) begin
                    rsp_id_d    = pick.idx[ID_W-1:0];
                    rsp_data_d  = '0;
                    issued_d    = '0;
                    collected_d = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                lfsr_en = (issued_q < CNT_W'(C));
                if (lfsr_en) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                if (lfsr_valid) begin
                    // Truncating cast drops the oldest chunk's upper neighbours;
                    // also covers WORD_WIDTH == BITS_PER_CLOCK.
                    rsp_data_d  = WORD_WIDTH'({rsp_data_q, lfsr_out});
                    collected_d = collected_q + CNT_W'(1);
                    if (collected_q == CNT_W'(C - 1)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            issued_q    <= '0;
            collected_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            issued_q    <= issued_d;
            collected_q <= collected_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Bench for lfsr_word_arbiter: directed scenarios with literal expectations
// plus a transaction-level model checked on every falling clock edge.
module tb_lfsr_word_arbiter;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_ready = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;

    lfsr_word_arbiter #(
        .NUM_REQ        (4),
        .WORD_WIDTH     (8),
        .BITS_PER_CLOCK (1),
        .LFSR_SEED      (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Owner of the current transaction (-1 = none), its age in cycles,
    // the round-robin pointer, and the generator polynomial state.
    int         m_owner = -1;
    int         m_age   = 0;
    int         m_ptr   = 0;
    logic [7:0] m_word  = '0;
    logic [8:0] g       = 9'h001;
    int         en_count = 0;

    always @(negedge clk) begin : model_check
        logic [3:0] exp_ready;
        int         winner;
        int         k;
        logic       exp_busy, exp_valid, bit_o;
        if (!reset_n) begin
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rsp_id",    32'(rsp_id),    32'h0);
            check("rst_rsp_data",  32'(rsp_data),  32'h0);
            check("rst_busy",      32'(busy),      32'h0);
            m_owner  = -1;
            m_age    = 0;
            m_ptr    = 0;
            g        = 9'h001;
            en_count = 0;
        end else begin
            exp_ready = '0;
            winner    = -1;
            if (m_owner < 0) begin
                for (int i = 0; i < 4; i++) begin
                    k = (m_ptr + i) % 4;
                    if (winner < 0 && req_valid[k]) winner = k;
                end
                if (winner >= 0) exp_ready[winner] = 1'b1;
            end
            exp_busy  = (m_owner >= 0) && (m_age >= 1);
            exp_valid = (m_owner >= 0) && (m_age >= C + 2);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy",      32'(busy),      32'(exp_busy));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("rsp_id",   32'(rsp_id),   32'(m_owner));
                check("rsp_data", 32'(rsp_data), 32'(m_word));
            end
            if (dut.lfsr_en) en_count = en_count + 1;

            if (m_owner >= 0) begin
                if (exp_valid && rsp_ready) begin
                    check("enable_count", 32'(en_count), 32'(C));
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (winner >= 0) begin
                m_owner  = winner;
                m_age    = 1;
                en_count = 0;
                // Next word: eight successive coefficients of x^7 in x^n mod p(x).
                for (int b = 0; b < 8; b++) begin
                    bit_o  = g[7];
                    m_word = {m_word[6:0], bit_o};
                    g      = {g[7:0], 1'b0};
                    if (g[8]) g = g ^ 9'h11D;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset(input logic [3:0] rv, input logic rr);
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        req_valid = rv;
        rsp_ready = rr;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = n;
                break;
            end
        end
        if (cyc < 0) check("rsp_timeout", 32'h0, 32'h1);
    endtask

    // Wait for requester idx to be accepted, then drop its request.
    task automatic wait_ready(input int idx);
        int found;
        found = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check("ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    initial begin : stim
        int         cyc;
        logic [1:0] hold_id;
        logic [7:0] hold_data;
        logic [7:0] t2_data [5];
        logic [1:0] t2_id   [5];
        t2_data = '{8'h01, 8'h1C, 8'h4B, 8'h81, 8'h92};
        t2_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // 1: single requester 0, rsp_ready high.
        do_reset(4'b0000, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_rsp(cyc);
        check("t1_latency", 32'(cyc + 1), 32'd10);
        check("t1_id",      32'(rsp_id),   32'h0);
        check("t1_data0",   32'(rsp_data), 32'h01);
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_rsp(cyc);
        check("t1_data1", 32'(rsp_data), 32'h1C);

        // 2: all requesters held high from reset.
        do_reset(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(cyc);
            check("t2_id",   32'(rsp_id),   32'(t2_id[i]));
            check("t2_data", 32'(rsp_data), 32'(t2_data[i]));
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (14) @(posedge clk);

        // 3: response held off for 20 cycles.
        do_reset(4'b0000, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 4'b0011;
        #1;
        check("t3_req_ready", 32'(req_ready), 32'h1);
        wait_ready(0);
        wait_rsp(cyc);
        check("t3_data", 32'(rsp_data), 32'h01);
        hold_id   = rsp_id;
        hold_data = rsp_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(rsp_valid), 32'h1);
            check("t3_hold_id",    32'(rsp_id),    32'(hold_id));
            check("t3_hold_data",  32'(rsp_data),  32'(hold_data));
            check("t3_no_ready",   32'(req_ready), 32'h0);
        end
        check("t3_enables", 32'(en_count), 32'd8);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_ready(1);
        wait_rsp(cyc);
        check("t3_id1",   32'(rsp_id),   32'h1);
        check("t3_data1", 32'(rsp_data), 32'h1C);

        // 4: reset in the middle of FILL, then reseeded generator.
        do_reset(4'b0000, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t4_busy",      32'(busy),      32'h0);
        check("t4_rsp_id",    32'(rsp_id),    32'h0);
        check("t4_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t4_rsp_data",  32'(rsp_data),  32'h0);
        check("t4_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        wait_ready(2);
        wait_rsp(cyc);
        check("t4_id",   32'(rsp_id),   32'h2);
        check("t4_data", 32'(rsp_data), 32'h01);

        // 6: pointer now 3; requesters 1 and 3 pending.
        @(posedge clk);
        #1;
        req_valid = 4'b1010;
        #1;
        check("t6_first_ready", 32'(req_ready), 32'h8);
        wait_ready(3);
        wait_rsp(cyc);
        check("t6_id3",   32'(rsp_id),   32'h3);
        check("t6_data3", 32'(rsp_data), 32'h1C);
        wait_ready(1);
        wait_rsp(cyc);
        check("t6_id1",   32'(rsp_id),   32'h1);
        check("t6_data1", 32'(rsp_data), 32'h4B);

        // 5: requester 1 drops its request right after acceptance.
        do_reset(4'b0000, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        #1;
        check("t5_req_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_rsp(cyc);
        check("t5_id",   32'(rsp_id),   32'h1);
        check("t5_data", 32'(rsp_data), 32'h01);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_word_arbiter.md
# lfsr_word_arbiter

Shares a single 8-bit Galois LFSR random-bit generator among `NUM_REQ` requesters. Each accepted request receives one `WORD_WIDTH`-bit random word, assembled from successive LFSR output chunks. Grants are round-robin, and the arbiter owns the generator's `enable` exclusively. It sits between the random-number consumers (test-pattern, backoff and dither logic) and the generator instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WORD_WIDTH`, 8: bits per delivered word. Must be a multiple of `BITS_PER_CLOCK`.
- `BITS_PER_CLOCK`, 1: generator output bits per enabled cycle, 1..8. Passed to the generator.
- `LFSR_SEED`, 1: generator seed. Passed to the generator.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester level request. Must be held until accepted.
- `req_ready` out `NUM_REQ`: one-hot acceptance pulse, combinational from `req_valid` and state.
- `rsp_valid` out 1: response word available. Registered.
- `rsp_id` out `$clog2(NUM_REQ)`: index of the requester that owns the response.
- `rsp_data` out `WORD_WIDTH`: random word.
- `rsp_ready` in 1: the consumer identified by `rsp_id` accepts the word.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Chunk count:** C = `WORD_WIDTH` / `BITS_PER_CLOCK`. Two counters, `issued` and `collected`, each `$clog2(C+1)` bits wide.
- **IDLE:**
  - If any `req_valid` bit is set, the round-robin pick is the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - The picked requester's `req_ready` bit is 1 for that cycle. The index is latched into `rsp_id`, `rsp_data` is cleared, and the state moves to FILL.
  - `req_ready` is all zeros in every other state and whenever `req_valid` is zero.
- **FILL:**
  - Generator `enable` = (`issued` < C). `issued` increments on each enabled cycle.
  - On each generator `lfsr_valid`: `rsp_data` <= {`rsp_data[WORD_WIDTH-BITS_PER_CLOCK-1:0]`, `lfsr_out`}, so the first chunk lands in the MSBs. `collected` increments.
  - When `collected` reaches C, the state moves to RESP and `rsp_valid` becomes 1.
- **RESP:**
  - `rsp_valid`, `rsp_id` and `rsp_data` are held stable until `rsp_valid` && `rsp_ready`.
  - On that handshake: `rsp_valid` <= 0, `rr_ptr` <= `rsp_id`+1 (wrapping from `NUM_REQ`-1 to 0), and the state returns to IDLE.
- **Generator state:** the generator advances only on enabled cycles, so its sequence is continuous across grants and shared among all requesters.
- **Requester behaviour:**
  - Deasserting `req_valid` after acceptance has no effect.
  - A requester whose `req_valid` is still high after its response is re-arbitrated normally and receives no priority.
- **Reset (any state, including mid-FILL):**
  - State returns to IDLE; `rr_ptr` = 0; `issued` and `collected` = 0.
  - Outputs: `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `busy` 0, `req_ready` 0.
  - The generator is reseeded to `LFSR_SEED`. A partially assembled word is discarded.

## Timing
- Acceptance happens at cycle 0. FILL runs cycles 1..C with `enable` high. `lfsr_valid` returns on cycles 2..C+1.
- `rsp_valid` rises on cycle C+2. The earliest next acceptance is the cycle after the handshake.
- Minimum turnaround is C+3 cycles per word.
- `busy` is registered. It is high from cycle 1 through the handshake cycle.
- A `rsp_ready` that is high before `rsp_valid` is ignored.
- `rsp_ready` held high gives a single-cycle `rsp_valid` pulse.

## Structure
- Package `lfsr_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, FILL, RESP);
  - the width helper functions for the counter and the id.
- One sub-module: `galois_lfsr`, instantiated once, with `LFSR_WIDTH`=8 and the `BITS_PER_CLOCK` and `LFSR_SEED` parameters passed through.
- The round-robin pick is a function in the package, not a separate module.
- Parameter checks (`WORD_WIDTH` % `BITS_PER_CLOCK` == 0, `NUM_REQ` range) are made with elaboration-time assertions.

## Test plan
All scenarios use `NUM_REQ`=4, `WORD_WIDTH`=8, `BITS_PER_CLOCK`=1, seed 1.
1. Single requester 0, `rsp_ready` tied high:
   - `req_ready[0]` pulses at cycle 0 and `rsp_valid` rises at cycle 10 with `rsp_id`=0, `rsp_data`=0x01.
   - A second request returns `rsp_data`=0x1C.
2. All four `req_valid` held high from reset: grants go in order 0,1,2,3,0; each `req_ready` pulse is one-hot; words are 0x01, 0x1C, …, continuing the generator sequence.
3. `rsp_ready` held low for 20 cycles in RESP: `rsp_valid`, `rsp_id` and `rsp_data` stay stable, no `req_ready` pulse occurs, and the `enable` count stays 8.
4. `reset_n` asserted on cycle 4 of FILL:
   - All outputs go to 0 immediately.
   - After release, requester 2 alone receives 0x01, showing the generator was reseeded.
5. Requester 1 drops `req_valid` the cycle after acceptance: the response still completes with `rsp_id`=1.
6. With `rr_ptr`=3, requesters 1 and 3 pending: requester 3 is granted first, then requester 1.
